run_supervisor: RTL
===================

Name: run_supervisor

Overview:
- Kernel-level run controller placed directly downstream of the watchdog timer. It consumes the timer's one-cycle time_out pulse and the merger core's completion pulse.
- It converts host ap_start into a single core start pulse and reports completion through ap_done, ap_idle and ap_ready.
- On watchdog expiry it forces a bounded pipeline flush and completes the run with a sticky timeout status.
- It also measures the run length in cycles for host readback.

Parameters:
- CNT_W, 32, width of run_cycles.
- FLUSH_CYCLES, 16, number of cycles flush_req is held after a timeout; legal range is 1 or more.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- ap_start  in  1  host start, level; also fans out to the watchdog timer.
- time_out  in  1  watchdog expiry pulse, 1 cycle.
- core_done  in  1  merger core completion pulse, 1 cycle.
- core_start  out  1  start pulse to the merger core, 1 cycle.
- flush_req  out  1  forces the core pipeline to drain and discard data.
- ap_ready  out  1  start accepted, 1-cycle pulse.
- ap_done  out  1  run finished (normal or timeout), 1-cycle pulse.
- ap_idle  out  1  high while in IDLE.
- status_timeout  out  1  sticky: last run ended by timeout.
- run_cycles  out  CNT_W  cycles spent in RUN during the last or current run.

Behaviour:
- One clock domain, aclk. Reset is asynchronous and active-low on aresetn; release is synchronised externally.
- Reset values:
  - State is IDLE and ap_idle=1.
  - core_start, flush_req, ap_ready, ap_done, status_timeout = 0.
  - run_cycles = 0 and the flush counter = 0.
  - Reset asserted mid-RUN or mid-FLUSH aborts immediately to these values; no ap_done is produced.
- All outputs are registered.
- The FSM has three states: IDLE, RUN, FLUSH.
- IDLE:
  - ap_start=1 sampled at edge k: in cycle k+1 the state is RUN, with core_start=1, ap_ready=1, ap_idle=0, run_cycles=0 and status_timeout cleared.
  - time_out and core_done are ignored in IDLE.
- RUN:
  - run_cycles increments at every edge while in RUN and saturates at all-ones with no wrap. It therefore equals the number of cycles spent in RUN.
  - core_done=1 sampled: next cycle the state is IDLE, with ap_done=1 for that cycle only and ap_idle=1.
  - time_out=1 with core_done=0 sampled: next cycle the state is FLUSH, with flush_req=1, status_timeout=1 and the flush counter loaded with FLUSH_CYCLES-1.
  - core_done and time_out in the same cycle: done wins, the run completes normally and status_timeout stays 0.
  - ap_start is ignored while in RUN; no re-trigger and no second core_start.
- FLUSH:
  - flush_req stays high for exactly FLUSH_CYCLES consecutive cycles. The counter decrements each cycle.
  - The cycle after the counter reaches 0 (last flush cycle): state is IDLE, with flush_req=0, ap_done=1 for 1 cycle and ap_idle=1.
  - core_done, time_out and ap_start are ignored in FLUSH.
  - run_cycles is frozen in FLUSH.
- Persistence:
  - status_timeout and run_cycles hold their values in IDLE until the next accepted start.
- Back-to-back runs:
  - ap_start held high through completion is accepted on the first IDLE cycle.
  - ap_done (cycle n) is followed by core_start in cycle n+1.
  - Minimum start-to-start period is 3 cycles.

Test Plan:
- Reset, then ap_start=1 for 1 cycle at cycle 5 -> cycle 6 core_start=1, ap_ready=1, ap_idle=0. Then core_done at cycle 105 -> cycle 106 ap_done=1, ap_idle=1, run_cycles=100, status_timeout=0.
- Start, no core_done, time_out at RUN cycle 50 -> flush_req high for exactly 16 cycles, status_timeout=1, ap_done 1 cycle after flush_req falls, run_cycles=50. Repeat with FLUSH_CYCLES=1 -> flush_req high for 1 cycle.
- core_done and time_out in the same RUN cycle -> no flush_req, ap_done next cycle, status_timeout=0. Extra time_out or core_done pulses in IDLE or FLUSH -> no state change and no extra ap_done.
- ap_start held high continuously for 3 runs, each with core_done 10 cycles after start -> exactly one core_start per run, core_start in the cycle after each ap_done, status_timeout of a prior timed-out run cleared at the next start.
- aresetn low mid-RUN (cycle 20) and mid-FLUSH (cycle 5 of flush) -> all outputs go to reset values asynchronously, ap_idle=1, no ap_done. Normal run works after release.
- With CNT_W=4, a run of 20 cycles -> run_cycles saturates at 15 and does not wrap.

Source files
------------

// File: rtl/run_supervisor.sv
// run_supervisor
// ----------------------------------------------------------------------------
// Kernel-level run controller that sits downstream of the watchdog timer.
// It turns the host ap_start level into a single core_start pulse and
// reports completion through ap_done / ap_idle / ap_ready. A watchdog expiry
// forces a bounded pipeline flush (flush_req held for FLUSH_CYCLES cycles)
// and ends the run with a sticky timeout status. run_cycles counts the
// cycles spent in RUN for host readback.
//
// Handshake: ap_start is a level. It is accepted only in IDLE; acceptance is
// signalled by a one-cycle ap_ready together with a one-cycle core_start.
// ap_done is a one-cycle pulse on the first IDLE cycle after a run. ap_start
// still high on that cycle is accepted immediately (back-to-back runs).
//
// Parameters:
//   CNT_W        - width of run_cycles
//   FLUSH_CYCLES - number of cycles flush_req is held after a timeout (>= 1)
//
// Ports:
//   aclk           in   clock
//   aresetn        in   asynchronous active-low reset
//   ap_start       in   host start (level)
//   time_out       in   watchdog expiry pulse
//   core_done      in   core completion pulse
//   core_start     out  one-cycle start pulse to the core
//   flush_req      out  forces the core pipeline to drain and discard data
//   ap_ready       out  one-cycle start-accepted pulse
//   ap_done        out  one-cycle run-finished pulse (normal or timeout)
//   ap_idle        out  high while in IDLE
//   status_timeout out  sticky: last run ended by timeout
//   run_cycles     out  cycles spent in RUN during the last or current run
//   fsm_state      out  current FSM state (0 IDLE, 1 RUN, 2 FLUSH) for debug
// ----------------------------------------------------------------------------
module run_supervisor #(
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             ap_start,
    input  logic             time_out,
    input  logic             core_done,
    output logic             core_start,
    output logic             flush_req,
    output logic             ap_ready,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             status_timeout,
    output logic [CNT_W-1:0] run_cycles,
    output logic [1:0]       fsm_state
);

    // Flush counter only needs to hold FLUSH_CYCLES-1.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [FC_W-1:0]  flush_cnt;
    logic [FC_W-1:0]  flush_cnt_nxt;
    logic [CNT_W-1:0] run_cycles_nxt;
    logic             core_start_nxt;
    logic             flush_req_nxt;
    logic             ap_ready_nxt;
    logic             ap_done_nxt;
    logic             ap_idle_nxt;
    logic             status_timeout_nxt;
    logic             start_acc;
    logic             to_flush;

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (ap_start) state_nxt = S_RUN;
            end
            S_RUN: begin
                // Completion beats a simultaneous watchdog expiry.
                if (core_done)     state_nxt = S_IDLE;
                else if (time_out) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of every registered output
    // ------------------------------------------------------------------
    always_comb begin
        start_acc          = (state == S_IDLE) && (state_nxt == S_RUN);
        to_flush           = (state == S_RUN) && (state_nxt == S_FLUSH);

        core_start_nxt     = start_acc;
        ap_ready_nxt       = start_acc;
        ap_done_nxt        = (state != S_IDLE) && (state_nxt == S_IDLE);
        ap_idle_nxt        = (state_nxt == S_IDLE);
        flush_req_nxt      = (state_nxt == S_FLUSH);

        status_timeout_nxt = status_timeout;
        if (start_acc)     status_timeout_nxt = 1'b0;
        else if (to_flush) status_timeout_nxt = 1'b1;

        // Counts every edge taken in RUN, including the exiting edge, so the
        // final value equals the number of cycles spent in RUN.
        run_cycles_nxt = run_cycles;
        if (start_acc) begin
            run_cycles_nxt = '0;
        end else if ((state == S_RUN) && (run_cycles != CNT_MAX)) begin
            run_cycles_nxt = run_cycles + CNT_W'(1);
        end

        flush_cnt_nxt = flush_cnt;
        if (to_flush) begin
            flush_cnt_nxt = FLUSH_LOAD;
        end else if ((state == S_FLUSH) && (flush_cnt != '0)) begin
            flush_cnt_nxt = flush_cnt - FC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            core_start     <= 1'b0;
            flush_req      <= 1'b0;
            ap_ready       <= 1'b0;
            ap_done        <= 1'b0;
            ap_idle        <= 1'b1;
            status_timeout <= 1'b0;
            run_cycles     <= '0;
            flush_cnt      <= '0;
        end else begin
            core_start     <= core_start_nxt;
            flush_req      <= flush_req_nxt;
            ap_ready       <= ap_ready_nxt;
            ap_done        <= ap_done_nxt;
            ap_idle        <= ap_idle_nxt;
            status_timeout <= status_timeout_nxt;
            run_cycles     <= run_cycles_nxt;
            flush_cnt      <= flush_cnt_nxt;
        end
    end

endmodule
